// File: rtl/nts_tx_pkg.sv
// Shared FSM encoding, word geometry and byte-mask helper for the NTS Tx dispatch path.
package nts_tx_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_STREAM  = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Leading n bytes valid; first wire byte sits in the MSB lane.
  function automatic logic [BYTES_PER_WORD-1:0] mask_from_bytes(input logic [3:0] n);
    return ~({BYTES_PER_WORD{1'b1}} >> n);
  endfunction

endpackage

// File: rtl/nts_tx_dispatch_outreg.sv
// Two-stage FIFO-to-MAC pipeline: stage 1 tags the returning read data as last,
// stage 2 registers the word and its byte mask onto the MAC bus.
module nts_tx_dispatch_outreg
  import nts_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        rd_en_i,
  input  logic        flush_i,
  input  logic        fifo_empty_i,
  input  logic [63:0] rd_data_i,
  input  logic [3:0]  last_bytes_i,
  output logic        s1_last_o,
  output logic        s2_last_o,
  output logic [7:0]  mac_valid_o,
  output logic [63:0] mac_data_o
);

  logic        s1_valid_q;
  logic        s2_last_q;
  logic [7:0]  s2_mask_q;
  logic [7:0]  s2_mask_d;
  logic [63:0] s2_data_q;

  // A returning word is last when nothing remains behind it in the FIFO.
  assign s1_last_o = s1_valid_q & fifo_empty_i;

  always_comb begin
    s2_mask_d = '0;
    if (s1_valid_q && !flush_i) begin
      s2_mask_d = s1_last_o ? mask_from_bytes(last_bytes_i) : 8'hFF;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      s1_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mask_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en_i & ~flush_i;
      s2_last_q  <= s1_last_o & ~flush_i;
      s2_mask_q  <= s2_mask_d;
      if (s1_valid_q) begin
        s2_data_q <= rd_data_i;
      end
    end
  end

  assign s2_last_o   = s2_last_q;
  assign mac_valid_o = s2_mask_q;
  assign mac_data_o  = s2_data_q;

endmodule

// File: rtl/nts_tx_dispatcher.sv
// NTS Tx double-buffer drain: waits for a packet, wins the MAC slot, streams it and
// releases the buffer. Define NTS_TX_DISPATCH_STATS_EN to build the packet/drop counters.
module nts_tx_dispatcher
  import nts_tx_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter int IPG_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_tx_packet_available,
  output logic        o_tx_packet_read,
  input  logic        i_tx_fifo_empty,
  output logic        o_tx_fifo_rd_en,
  input  logic [63:0] i_tx_fifo_rd_data,
  input  logic [3:0]  i_tx_bytes_last_word,
  output logic        o_mac_tx_start,
  input  logic        i_mac_tx_ack,
  output logic [7:0]  o_mac_tx_data_valid,
  output logic [63:0] o_mac_tx_data,
  output logic        o_error,
  output logic [31:0] o_stat_packets,
  output logic [31:0] o_stat_drops
);

  localparam logic [15:0] TMO_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST   = 16'(IPG_CYCLES - 1);
  localparam state_t      POST_STATE = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic        err_q, err_d;
  logic        drain_q, drain_d;
  logic        first_q, first_d;

  logic rd_en;
  logic flush;
  logic pkt_done;
  logic drop;
  logic s1_last;
  logic s2_last;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    err_d    = err_q;
    drain_d  = drain_q;
    first_d  = 1'b0;
    rd_en    = 1'b0;
    flush    = 1'b0;
    pkt_done = 1'b0;
    drop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        drain_d = 1'b0;
        if (i_tx_packet_available) begin
          nbytes_d = i_tx_bytes_last_word;
          if ((i_tx_bytes_last_word == 4'd0) || (i_tx_bytes_last_word > 4'd8)) begin
            state_d = ST_RELEASE;
            err_d   = 1'b1;
            drop    = 1'b1;
          end else begin
            state_d = ST_REQUEST;
          end
        end
      end

      ST_REQUEST: begin
        if (!i_tx_packet_available) begin
          state_d = POST_STATE;
          err_d   = 1'b1;
        end else if (i_mac_tx_ack) begin
          state_d = ST_STREAM;
          first_d = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RELEASE;
          drop    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_STREAM: begin
        if (!i_tx_packet_available) begin
          state_d = POST_STATE;
          err_d   = 1'b1;
          flush   = 1'b1;
        end else if (first_q && i_tx_fifo_empty) begin
          state_d = ST_RELEASE;
          err_d   = 1'b1;
        end else begin
          // Once the last word has come back, no further reads may be issued.
          rd_en = ~i_tx_fifo_empty & ~drain_q;
          if (s1_last) begin
            drain_d = 1'b1;
          end
          if (s2_last) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (!i_tx_packet_available) begin
          state_d = POST_STATE;
          err_d   = 1'b1;
        end else begin
          state_d  = ST_RELEASE;
          pkt_done = 1'b1;
        end
      end

      ST_RELEASE: begin
        state_d = POST_STATE;
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state that times something starts counting from zero on entry.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      nbytes_q <= '0;
      err_q    <= 1'b0;
      drain_q  <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
      first_q  <= first_d;
    end
  end

  nts_tx_dispatch_outreg u_outreg (
    .i_clk        (i_clk),
    .i_areset     (i_areset),
    .rd_en_i      (rd_en),
    .flush_i      (flush),
    .fifo_empty_i (i_tx_fifo_empty),
    .rd_data_i    (i_tx_fifo_rd_data),
    .last_bytes_i (nbytes_q),
    .s1_last_o    (s1_last),
    .s2_last_o    (s2_last),
    .mac_valid_o  (o_mac_tx_data_valid),
    .mac_data_o   (o_mac_tx_data)
  );

  assign o_tx_fifo_rd_en  = rd_en;
  assign o_mac_tx_start   = (state_q == ST_REQUEST);
  assign o_tx_packet_read = (state_q == ST_RELEASE);
  assign o_error          = err_q;

`ifdef NTS_TX_DISPATCH_STATS_EN
  logic [31:0] stat_packets_q;
  logic [31:0] stat_drops_q;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      stat_packets_q <= '0;
      stat_drops_q   <= '0;
    end else begin
      if (pkt_done) begin
        stat_packets_q <= stat_packets_q + 32'd1;
      end
      if (drop) begin
        stat_drops_q <= stat_drops_q + 32'd1;
      end
    end
  end

  assign o_stat_packets = stat_packets_q;
  assign o_stat_drops   = stat_drops_q;
`else
  logic unused_stats;
  assign unused_stats   = pkt_done | drop;
  assign o_stat_packets = '0;
  assign o_stat_drops   = '0;
`endif

endmodule

// File: tb/tb_nts_tx_dispatcher.sv
// Directed bench for nts_tx_dispatcher: a FIFO model feeds the DUT, expected MAC words
// are queued when a packet is loaded and checked as they appear on the bus.
module tb_nts_tx_dispatcher;

  localparam int ACK_TO = 16;
  localparam int IPG    = 2;
`ifdef NTS_TX_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_areset = 1'b1;
  logic        i_tx_packet_available = 1'b0;
  logic        o_tx_packet_read;
  logic        i_tx_fifo_empty;
  logic        o_tx_fifo_rd_en;
  logic [63:0] i_tx_fifo_rd_data = '0;
  logic [3:0]  i_tx_bytes_last_word = '0;
  logic        o_mac_tx_start;
  logic        i_mac_tx_ack = 1'b0;
  logic [7:0]  o_mac_tx_data_valid;
  logic [63:0] o_mac_tx_data;
  logic        o_error;
  logic [31:0] o_stat_packets;
  logic [31:0] o_stat_drops;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_pkts = 0;
  int exp_drops = 0;

  logic [63:0] mem [0:255];
  int          wr_cnt = 0;
  int          rd_ptr = 0;
  logic        fifo_clr = 1'b0;

  logic [71:0] exp_q[$];
  int          word_cyc[$];
  int          rel_cyc[$];

  nts_tx_dispatcher #(
    .ACK_TIMEOUT (ACK_TO),
    .IPG_CYCLES  (IPG)
  ) dut (
    .i_clk                 (i_clk),
    .i_areset              (i_areset),
    .i_tx_packet_available (i_tx_packet_available),
    .o_tx_packet_read      (o_tx_packet_read),
    .i_tx_fifo_empty       (i_tx_fifo_empty),
    .o_tx_fifo_rd_en       (o_tx_fifo_rd_en),
    .i_tx_fifo_rd_data     (i_tx_fifo_rd_data),
    .i_tx_bytes_last_word  (i_tx_bytes_last_word),
    .o_mac_tx_start        (o_mac_tx_start),
    .i_mac_tx_ack          (i_mac_tx_ack),
    .o_mac_tx_data_valid   (o_mac_tx_data_valid),
    .o_mac_tx_data         (o_mac_tx_data),
    .o_error               (o_error),
    .o_stat_packets        (o_stat_packets),
    .o_stat_drops          (o_stat_drops)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // FIFO model: data for a read issued in cycle t is visible in cycle t+1.
  assign i_tx_fifo_empty = (rd_ptr == wr_cnt);

  always @(posedge i_clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_cnt;
    end else if (o_tx_fifo_rd_en && (rd_ptr != wr_cnt)) begin
      i_tx_fifo_rd_data <= mem[rd_ptr];
      rd_ptr            <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] exp_mask(input logic [3:0] n);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(n)) m[7-b] = 1'b1;
    end
    return m;
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic load_pkt(input int nwords, input logic [3:0] nb);
    logic [63:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = {$urandom, $urandom};
      mem[wr_cnt] = w;
      wr_cnt++;
      exp_q.push_back({w, (i == nwords - 1) ? exp_mask(nb) : 8'hFF});
    end
    i_tx_bytes_last_word = nb;
  endtask

  task automatic wait_start(input string tag, output int c);
    int n;
    n = 0;
    while (!o_mac_tx_start && n < 50) begin
      tick();
      n++;
    end
    c = cyc;
    chk(tag, {63'd0, o_mac_tx_start}, 64'd1);
  endtask

  task automatic wait_release(input string tag, output int c);
    int n;
    n = 0;
    while (!o_tx_packet_read && n < 50) begin
      tick();
      n++;
    end
    c = cyc;
    chk(tag, {63'd0, o_tx_packet_read}, 64'd1);
  endtask

  task automatic pulse_ack(output int c);
    i_mac_tx_ack = 1'b1;
    c = cyc;
    tick();
    i_mac_tx_ack = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkts"}, o_stat_packets, STATS ? exp_pkts : 0);
    chk({tag, "_drops"}, o_stat_drops, STATS ? exp_drops : 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, o_mac_tx_start, 0);
    chk({tag, "_read"}, o_tx_packet_read, 0);
    chk({tag, "_rd_en"}, o_tx_fifo_rd_en, 0);
    chk({tag, "_mask"}, o_mac_tx_data_valid, 0);
    chk({tag, "_data"}, o_mac_tx_data, 0);
    chk({tag, "_error"}, o_error, 0);
    chk_stats(tag);
  endtask

  // Bus monitor: every presented word must match the head of the scoreboard.
  always @(negedge i_clk) begin
    logic [71:0] e;
    if (o_tx_packet_read) rel_cyc.push_back(cyc);
    if (o_mac_tx_data_valid != 8'h00) begin
      word_cyc.push_back(cyc);
      chk("sb_word_expected", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data", o_mac_tx_data, e[71:8]);
        chk("sb_mask", {56'd0, o_mac_tx_data_valid}, {56'd0, e[7:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, t, r, s2, r2, n, nst;

    // Reset state
    repeat (3) tick();
    i_areset = 1'b0;
    tick();
    chk_idle_outputs("reset");

    // 3-word packet, 5 bytes in the last word, ack 4 cycles after start
    word_cyc.delete(); rel_cyc.delete();
    load_pkt(3, 4'd5);
    i_tx_packet_available = 1'b1;
    wait_start("t1_start", s);
    repeat (4) tick();
    chk("t1_start_held", o_mac_tx_start, 1);
    pulse_ack(t);
    chk("t1_start_dropped", o_mac_tx_start, 0);
    wait_release("t1_release", r);
    i_tx_packet_available = 1'b0;
    repeat (4) tick();
    exp_pkts = 1;
    chk("t1_word_count", word_cyc.size(), 3);
    chk("t1_first_word_cyc", word_cyc[0], t + 3);
    chk("t1_last_word_cyc", word_cyc[2], t + 5);
    chk("t1_release_cyc", r, t + 7);
    chk("t1_release_count", rel_cyc.size(), 1);
    chk("t1_sb_drained", exp_q.size(), 0);
    chk("t1_error", o_error, 0);
    chk_stats("t1");

    // No ack: start held for ACK_TIMEOUT cycles, then release and a drop
    word_cyc.delete(); rel_cyc.delete();
    i_tx_bytes_last_word = 4'd4;
    i_tx_packet_available = 1'b1;
    wait_start("t2_start", s);
    n = 0; nst = 0;
    while (!o_tx_packet_read && n < 60) begin
      if (o_mac_tx_start) nst++;
      tick();
      n++;
    end
    chk("t2_release_seen", o_tx_packet_read, 1);
    chk("t2_start_cycles", nst, ACK_TO);
    i_tx_packet_available = 1'b0;
    repeat (4) tick();
    exp_drops = 1;
    chk("t2_no_mac_words", word_cyc.size(), 0);
    chk("t2_release_count", rel_cyc.size(), 1);
    chk("t2_error", o_error, 0);
    chk_stats("t2");

    // Length error: bytes_last_word = 0
    word_cyc.delete(); rel_cyc.delete();
    i_tx_bytes_last_word = 4'd0;
    i_tx_packet_available = 1'b1;
    tick();
    chk("t3_release_now", o_tx_packet_read, 1);
    chk("t3_error", o_error, 1);
    chk("t3_no_start", o_mac_tx_start, 0);
    i_tx_packet_available = 1'b0;
    repeat (4) tick();
    exp_drops = 2;
    chk("t3_release_count", rel_cyc.size(), 1);
    chk("t3_error_sticky", o_error, 1);
    chk_stats("t3");

    // Back-to-back packets honour the inter-packet gap
    word_cyc.delete(); rel_cyc.delete();
    load_pkt(2, 4'd8);
    i_tx_packet_available = 1'b1;
    wait_start("t4_start1", s);
    pulse_ack(t);
    wait_release("t4_release1", r);
    load_pkt(2, 4'd6);
    wait_start("t4_start2", s2);
    chk("t4_gap_respected", {63'd0, (s2 - r) >= (IPG + 1)}, 64'd1);
    pulse_ack(t);
    wait_release("t4_release2", r2);
    i_tx_packet_available = 1'b0;
    repeat (4) tick();
    exp_pkts = 3;
    chk("t4_word_count", word_cyc.size(), 4);
    chk("t4_release_count", rel_cyc.size(), 2);
    chk("t4_sb_drained", exp_q.size(), 0);
    chk_stats("t4");

    // Single-word packet with a full last word
    word_cyc.delete(); rel_cyc.delete();
    load_pkt(1, 4'd8);
    i_tx_packet_available = 1'b1;
    wait_start("t5_start", s);
    pulse_ack(t);
    wait_release("t5_release", r);
    i_tx_packet_available = 1'b0;
    repeat (4) tick();
    exp_pkts = 4;
    chk("t5_word_count", word_cyc.size(), 1);
    chk("t5_word_cyc", word_cyc[0], t + 3);
    chk("t5_release_cyc", r, t + 5);
    chk("t5_sb_drained", exp_q.size(), 0);
    chk_stats("t5");

    // Reset in the middle of a stream, then a fresh packet
    load_pkt(6, 4'd2);
    i_tx_packet_available = 1'b1;
    wait_start("t6_start", s);
    pulse_ack(t);
    repeat (3) tick();
    chk("t6_midstream_mask", o_mac_tx_data_valid, 8'hFF);
    i_areset = 1'b1;
    i_tx_packet_available = 1'b0;
    #1;
    exp_pkts = 0;
    exp_drops = 0;
    chk_idle_outputs("t6_in_reset");
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    exp_q.delete(); word_cyc.delete(); rel_cyc.delete();
    tick();
    i_areset = 1'b0;
    tick();
    chk_idle_outputs("t6_after_reset");
    chk("t6_no_release", rel_cyc.size(), 0);
    load_pkt(2, 4'd3);
    i_tx_packet_available = 1'b1;
    wait_start("t6_start2", s);
    pulse_ack(t);
    wait_release("t6_release", r);
    i_tx_packet_available = 1'b0;
    repeat (4) tick();
    exp_pkts = 1;
    chk("t6_word_count", word_cyc.size(), 2);
    chk("t6_first_word_cyc", word_cyc[0], t + 3);
    chk("t6_release_cyc", r, t + 6);
    chk("t6_release_count", rel_cyc.size(), 1);
    chk("t6_sb_drained", exp_q.size(), 0);
    chk_stats("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
